mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/diagnostics RAM arbiter: state codes,
// default parameters, owner encoding and the latched request record.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int unsigned DEF_READ_LATENCY = 1;
  localparam int unsigned DEF_STARVE_LIMIT = 15;

  localparam logic OWNER_CPU  = 1'b0;
  localparam logic OWNER_DIAG = 1'b1;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_req_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val, input logic [7:0] lim);
    logic [7:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the shared RAM port and the owner flag.
// slave = arbiter side, master = requesters plus RAM model.
interface mem_arbiter_if;

  logic        cpu_halted;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic        diag_req;
  logic        diag_we;
  logic [15:0] diag_addr;
  logic [7:0]  diag_wdata;
  logic        diag_ack;
  logic [7:0]  diag_rdata;

  logic        ram_cs;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic        owner;

  modport slave (
    input  cpu_halted, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  diag_req, diag_we, diag_addr, diag_wdata,
    output diag_ack, diag_rdata,
    output ram_cs, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output owner
  );

  modport master (
    output cpu_halted, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output diag_req, diag_we, diag_addr, diag_wdata,
    input  diag_ack, diag_rdata,
    input  ram_cs, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  owner
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port RAM. CPU has priority, but after
// STARVE_LIMIT consecutive contested CPU wins the diagnostics port is served.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic          fpga_clk,
  input logic          fpga_reset,
  mem_arbiter_if.slave bus
);

  localparam logic [7:0] STARVE_LIM_C = 8'(STARVE_LIMIT);
  localparam logic [1:0] LAT_LAST_C   = 2'(READ_LATENCY - 1);

  logic [1:0]  state_r;
  logic [1:0]  wait_cnt_r;
  logic [7:0]  starve_cnt_r;
  logic        holdoff_r;
  logic        ram_cs_r;
  logic        ram_we_r;
  logic [15:0] ram_addr_r;
  logic [7:0]  ram_wdata_r;
  logic        cpu_ack_r;
  logic        diag_ack_r;
  logic [7:0]  cpu_rdata_r;
  logic [7:0]  diag_rdata_r;
  logic        owner_r;

  logic        cpu_eff_s;
  logic        diag_eff_s;
  logic        contest_s;
  logic        grant_cpu_s;
  logic        grant_diag_s;
  mem_req_t    grant_req_s;

  assign cpu_eff_s  = bus.cpu_req && !bus.cpu_halted;
  assign diag_eff_s = bus.diag_req;
  assign contest_s  = cpu_eff_s && diag_eff_s;

  // Grant decision; holdoff blocks the IDLE cycle right after an ack so a
  // requester that has not yet dropped its req is not served twice.
  always_comb begin
    grant_cpu_s  = 1'b0;
    grant_diag_s = 1'b0;
    if ((state_r == ST_IDLE) && !holdoff_r) begin
      if (contest_s) begin
        if ((starve_cnt_r == STARVE_LIM_C) || bus.cpu_halted) begin
          grant_diag_s = 1'b1;
        end else begin
          grant_cpu_s = 1'b1;
        end
      end else if (cpu_eff_s) begin
        grant_cpu_s = 1'b1;
      end else if (diag_eff_s) begin
        grant_diag_s = 1'b1;
      end else begin
        grant_cpu_s  = 1'b0;
        grant_diag_s = 1'b0;
      end
    end else begin
      grant_cpu_s  = 1'b0;
      grant_diag_s = 1'b0;
    end
  end

  // Winner's request fields, latched into the RAM port registers on grant.
  always_comb begin
    grant_req_s = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
    if (grant_diag_s) begin
      grant_req_s = '{we: bus.diag_we, addr: bus.diag_addr, wdata: bus.diag_wdata};
    end else begin
      grant_req_s = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
    end
  end

  // Transaction FSM with registered RAM port, acks, read data and starvation count.
  always_ff @(posedge fpga_clk) begin
    if (fpga_reset) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= 2'd0;
      starve_cnt_r <= 8'd0;
      holdoff_r    <= 1'b0;
      ram_cs_r     <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= 16'h0000;
      ram_wdata_r  <= 8'h00;
      cpu_ack_r    <= 1'b0;
      diag_ack_r   <= 1'b0;
      cpu_rdata_r  <= 8'h00;
      diag_rdata_r <= 8'h00;
      owner_r      <= OWNER_CPU;
    end else begin
      cpu_ack_r  <= 1'b0;
      diag_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          holdoff_r <= 1'b0;
          ram_cs_r  <= 1'b0;
          ram_we_r  <= 1'b0;
          if (grant_cpu_s || grant_diag_s) begin
            state_r     <= ST_ACCESS;
            ram_cs_r    <= 1'b1;
            ram_we_r    <= grant_req_s.we;
            ram_addr_r  <= grant_req_s.addr;
            ram_wdata_r <= grant_req_s.wdata;
            owner_r     <= grant_diag_s ? OWNER_DIAG : OWNER_CPU;
            if (grant_diag_s) begin
              starve_cnt_r <= 8'd0;
            end else if (contest_s) begin
              starve_cnt_r <= sat_inc8(starve_cnt_r, STARVE_LIM_C);
            end else begin
              starve_cnt_r <= starve_cnt_r;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          ram_we_r <= 1'b0;
          // ram_we_r still holds the latched direction during ACCESS
          if (ram_we_r) begin
            state_r    <= ST_DONE;
            ram_cs_r   <= 1'b0;
            cpu_ack_r  <= (owner_r == OWNER_CPU);
            diag_ack_r <= (owner_r == OWNER_DIAG);
          end else begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= 2'd0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == LAT_LAST_C) begin
            state_r    <= ST_DONE;
            ram_cs_r   <= 1'b0;
            cpu_ack_r  <= (owner_r == OWNER_CPU);
            diag_ack_r <= (owner_r == OWNER_DIAG);
            if (owner_r == OWNER_DIAG) begin
              diag_rdata_r <= bus.ram_rdata;
            end else begin
              cpu_rdata_r <= bus.ram_rdata;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          holdoff_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_IDLE;
          ram_cs_r <= 1'b0;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_cs     = ram_cs_r;
  assign bus.ram_we     = ram_we_r;
  assign bus.ram_addr   = ram_addr_r;
  assign bus.ram_wdata  = ram_wdata_r;
  assign bus.cpu_ack    = cpu_ack_r;
  assign bus.diag_ack   = diag_ack_r;
  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.diag_rdata = diag_rdata_r;
  assign bus.owner      = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (READ_LATENCY=1, STARVE_LIMIT=3) with a
// one-cycle registered RAM model and a negedge activity monitor.
module tb_mem_arbiter;

  logic fpga_clk;
  logic fpga_reset;
  int   vectors;
  int   miscompares;

  mem_arbiter_if bus ();

  mem_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(3)) dut (
    .fpga_clk  (fpga_clk),
    .fpga_reset(fpga_reset),
    .bus       (bus)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // RAM model: registered read, one cycle after cs/addr; preloads on reset
  logic [7:0] mem [0:65535];
  always @(posedge fpga_clk) begin
    if (fpga_reset) begin
      mem[16'h1234] <= 8'hA5;
      mem[16'h0042] <= 8'h5A;
      mem[16'h0100] <= 8'hC3;
      bus.ram_rdata <= 8'h00;
    end else if (bus.ram_cs) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  int   ack_total, cpu_ack_total, diag_ack_total, cs_total, we_total, overlap_total;
  logic ack_log [0:255];
  initial begin
    ack_total = 0; cpu_ack_total = 0; diag_ack_total = 0;
    cs_total = 0; we_total = 0; overlap_total = 0;
  end
  always @(negedge fpga_clk) begin
    if (bus.cpu_ack && bus.diag_ack) overlap_total++;
    if (bus.cpu_ack || bus.diag_ack) begin
      ack_log[ack_total % 256] = bus.diag_ack;
      ack_total++;
    end
    if (bus.cpu_ack) cpu_ack_total++;
    if (bus.diag_ack) diag_ack_total++;
    if (bus.ram_cs) cs_total++;
    if (bus.ram_cs && bus.ram_we) we_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while ((ack_total < target) && (n < budget)) begin
      tick();
      n++;
    end
    chk("ack_wait_budget", 32'(ack_total >= target), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_cs"}, 32'(bus.ram_cs), 32'd0);
    chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
    chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
    chk({tag, "_acks"}, 32'({bus.cpu_ack, bus.diag_ack}), 32'd0);
    chk({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'd0);
    chk({tag, "_diag_rdata"}, 32'(bus.diag_rdata), 32'd0);
    chk({tag, "_owner"}, 32'(bus.owner), 32'd0);
  endtask

  int s_ack, s_cpu, s_diag, s_cs, s_we;

  initial begin
    vectors = 0;
    miscompares = 0;
    fpga_reset = 1'b1;
    bus.cpu_halted = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
    bus.diag_req = 1'b0; bus.diag_we = 1'b0;
    bus.diag_addr = 16'h0000; bus.diag_wdata = 8'h00;
    idle(2);
    chk_reset_outputs("reset");

    // CPU read 0x1234 -> A5, issued on the first edge after reset drops
    fpga_reset = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
    s_cs = cs_total;
    tick();
    chk("rd_access_cs", 32'(bus.ram_cs), 32'd1);
    chk("rd_access_addr", 32'(bus.ram_addr), 32'h1234);
    chk("rd_access_we", 32'(bus.ram_we), 32'd0);
    tick();
    chk("rd_wait_ack", 32'(bus.cpu_ack), 32'd0);
    tick();
    chk("rd_done_ack", 32'({bus.cpu_ack, bus.diag_ack}), 32'b10);
    chk("rd_rdata", 32'(bus.cpu_rdata), 32'hA5);
    bus.cpu_req = 1'b0;
    tick();
    chk("rd_ack_pulse", 32'(bus.cpu_ack), 32'd0);
    chk("rd_rdata_held", 32'(bus.cpu_rdata), 32'hA5);
    chk("rd_cs_cycles", 32'(cs_total - s_cs), 32'd2);
    idle(1);

    // Diag write 0xFFFF <= 3C, req held through the cycle after ack
    bus.diag_req = 1'b1; bus.diag_we = 1'b1; bus.diag_addr = 16'hFFFF; bus.diag_wdata = 8'h3C;
    s_we = we_total; s_cs = cs_total;
    tick();
    chk("wr_access", 32'({bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata}), {7'd0, 1'b1, 1'b1, 16'hFFFF, 8'h3C});
    chk("wr_owner", 32'(bus.owner), 32'd1);
    tick();
    chk("wr_done_ack", 32'({bus.cpu_ack, bus.diag_ack}), 32'b01);
    chk("wr_done_cs", 32'({bus.ram_cs, bus.ram_we}), 32'd0);
    idle(2);
    chk("wr_no_resample", 32'(bus.ram_cs), 32'd0);
    bus.diag_req = 1'b0;
    idle(1);
    chk("wr_we_cycles", 32'(we_total - s_we), 32'd1);
    chk("wr_cs_cycles", 32'(cs_total - s_cs), 32'd1);

    // CPU write then read at address 0x0000
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h77;
    tick();
    chk("zero_wr_access", 32'({bus.ram_we, bus.ram_addr}), {15'd0, 1'b1, 16'h0000});
    tick();
    chk("zero_wr_ack", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req = 1'b0;
    idle(2);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    idle(3);
    chk("zero_rd_ack", 32'(bus.cpu_ack), 32'd1);
    chk("zero_rd_rdata", 32'(bus.cpu_rdata), 32'h77);
    bus.cpu_req = 1'b0;
    idle(2);

    // Both requesting continuously: CPU,CPU,CPU,diag repeating
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h11;
    bus.diag_req = 1'b1; bus.diag_we = 1'b1; bus.diag_addr = 16'h0020; bus.diag_wdata = 8'h22;
    s_ack = ack_total;
    wait_acks(s_ack + 8, 100);
    bus.cpu_req = 1'b0; bus.diag_req = 1'b0;
    idle(3);
    chk("starve_ack_count", 32'(ack_total - s_ack), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("starve_order_%0d", i), 32'(ack_log[(s_ack + i) % 256]), 32'((i % 4) == 3));
    end

    // CPU halted: only diag served
    bus.cpu_halted = 1'b1;
    bus.cpu_req = 1'b1; bus.diag_req = 1'b1;
    s_ack = ack_total; s_cpu = cpu_ack_total; s_diag = diag_ack_total;
    wait_acks(s_ack + 3, 60);
    bus.cpu_req = 1'b0; bus.diag_req = 1'b0;
    idle(3);
    chk("halt_cpu_acks", 32'(cpu_ack_total - s_cpu), 32'd0);
    chk("halt_diag_acks", 32'(diag_ack_total - s_diag), 32'd3);
    bus.cpu_halted = 1'b0;

    // Diag read 0x0042, req dropped during ACCESS
    bus.diag_req = 1'b1; bus.diag_we = 1'b0; bus.diag_addr = 16'h0042;
    s_cs = cs_total; s_diag = diag_ack_total;
    tick();
    bus.diag_req = 1'b0;
    idle(2);
    chk("drop_ack", 32'({bus.cpu_ack, bus.diag_ack}), 32'b01);
    chk("drop_rdata", 32'(bus.diag_rdata), 32'h5A);
    idle(4);
    chk("drop_cs_cycles", 32'(cs_total - s_cs), 32'd2);
    chk("drop_ack_count", 32'(diag_ack_total - s_diag), 32'd1);

    // Reset during WAIT of a diag read, then a fresh CPU read
    bus.diag_req = 1'b1; bus.diag_we = 1'b0; bus.diag_addr = 16'h0100;
    s_diag = diag_ack_total;
    idle(2);
    chk("rst_in_wait_cs", 32'(bus.ram_cs), 32'd1);
    fpga_reset = 1'b1;
    tick();
    chk_reset_outputs("rst_mid");
    fpga_reset = 1'b0;
    bus.diag_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
    tick();
    chk("post_rst_grant", 32'({bus.ram_cs, bus.ram_addr}), {15'd0, 1'b1, 16'h1234});
    idle(2);
    chk("post_rst_ack", 32'({bus.cpu_ack, bus.diag_ack}), 32'b10);
    chk("post_rst_rdata", 32'(bus.cpu_rdata), 32'hA5);
    bus.cpu_req = 1'b0;
    idle(2);
    chk("rst_no_diag_ack", 32'(diag_ack_total - s_diag), 32'd0);
    chk("ack_overlap", 32'(overlap_total), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
